// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO on a valid/ready stream feeding a
// serialiser whose bit period is 2*BAUDSEL clocks. tx idles high and comes from a flop.
module uart_tx_fifo #(
  parameter int BAUDSEL    = 2,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [7:0]            tx_data,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam int                  CW      = $clog2(2 * BAUDSEL);
  localparam logic [CW-1:0]       CNT_MAX = CW'(2 * BAUDSEL - 1);
  localparam logic [CW-1:0]       CNT_ONE = CW'(1);
  localparam logic [DEPTH_LOG2:0] FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  state_t                state;
  logic [CW-1:0]         cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic                  push;
  logic                  pop;

  // Ready is derived from registered occupancy only, so a full FIFO refuses a
  // byte even on the edge where the serialiser frees a slot.
  assign tx_ready = resetn & (level != FULL);
  assign push     = tx_valid & tx_ready;
  assign pop      = (state == IDLE) & (level != '0);
  assign busy     = (state != IDLE) | (level != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop) begin
        rptr <= rptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // The next tx value is computed one edge ahead so the line only moves on bit boundaries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift <= mem[rptr];
            cnt   <= CNT_MAX;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cnt == '0) begin
            cnt     <= CNT_MAX;
            bit_idx <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        DATA: begin
          if (cnt == '0) begin
            cnt <= CNT_MAX;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STOP: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: reset/single-frame vector table, directed corner sequences,
// and random traffic compared every cycle against a frame-timing model.
module tb_uart_tx_fifo;

  localparam int BAUDSEL    = 2;
  localparam int DEPTH_LOG2 = 4;
  localparam int BIT        = 2 * BAUDSEL;
  localparam int FRAME      = 10 * BIT;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int NVEC       = 49;

  logic                clk = 1'b0;
  logic                resetn;
  logic                tx_valid;
  logic                tx_ready;
  logic [7:0]          tx_data;
  logic                tx;
  logic                busy;
  logic [DEPTH_LOG2:0] level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_on = 1'b0;
  int nxt;

  // Model: each accepted byte remembers its push edge and the edge its frame starts.
  int         push_t[$];
  int         start_t[$];
  logic [7:0] byte_q[$];

  typedef struct {
    logic                resetn;
    logic                valid;
    logic [7:0]          data;
    logic                tx;
    logic                ready;
    logic [DEPTH_LOG2:0] level;
    logic                busy;
  } vec_t;

  vec_t vecs [NVEC];

  uart_tx_fifo #(.BAUDSEL(BAUDSEL), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx(tx), .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  function automatic int m_level(int t);
    int n = 0;
    foreach (push_t[i]) if (push_t[i] <= t) n++;
    foreach (start_t[i]) if (start_t[i] <= t) n--;
    return n;
  endfunction

  function automatic int m_frame(int t);
    foreach (start_t[i]) if (t >= start_t[i] && t < start_t[i] + FRAME) return i;
    return -1;
  endfunction

  function automatic logic m_tx(int t);
    int k;
    int b;
    logic [7:0] d;
    k = m_frame(t);
    if (k < 0) return 1'b1;
    b = (t - start_t[k]) / BIT;
    d = byte_q[k];
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return 1'b1;
  endfunction

  function automatic vec_t mk(logic r, logic v, logic [7:0] d, logic t, logic rd, int lv, logic b);
    vec_t x;
    x.resetn = r; x.valid = v; x.data = d; x.tx = t; x.ready = rd;
    x.level = (DEPTH_LOG2 + 1)'(lv); x.busy = b;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic v, input logic [7:0] d);
    resetn = r; tx_valid = v; tx_data = d;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_output("idle_reached", 32'(busy), 32'd0);
  endtask

  // Bench receiver: finds the start edge, samples mid-bit, checks framing and spacing.
  task automatic rx_frame(input logic [7:0] exp_byte, input int prev_start, output int start);
    int n = 0;
    logic [7:0] b;
    logic ok;
    start = -1;
    while (tx !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) begin
      check_output("rx_start_seen", 32'(tx), 32'd0);
      return;
    end
    start = cyc;
    repeat (BIT / 2) @(negedge clk);
    ok = (tx === 1'b0);
    for (int j = 0; j < 8; j++) begin
      repeat (BIT) @(negedge clk);
      b[j] = tx;
    end
    repeat (BIT) @(negedge clk);
    ok = ok & (tx === 1'b1);
    check_output("rx_framing", 32'(ok), 32'd1);
    check_output("rx_byte", 32'(b), 32'(exp_byte));
    if (prev_start >= 0) check_output("rx_start_spacing", 32'(start - prev_start), 32'(FRAME + 1));
  endtask

  // Model update: acceptance uses the model's own pre-edge occupancy.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!resetn) begin
      push_t.delete();
      start_t.delete();
      byte_q.delete();
      model_on = 1'b1;
    end else if (tx_valid && m_level(cyc - 1) != DEPTH) begin
      nxt = cyc + 1;
      if (start_t.size() != 0 && start_t[$] + FRAME + 1 > nxt) nxt = start_t[$] + FRAME + 1;
      push_t.push_back(cyc);
      start_t.push_back(nxt);
      byte_q.push_back(tx_data);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (model_on) begin
      check_output("model_tx", 32'(tx), 32'(m_tx(cyc)));
      check_output("model_level", 32'(level), 32'(m_level(cyc)));
      check_output("model_ready", 32'(tx_ready), 32'(resetn && m_level(cyc) != DEPTH));
      check_output("model_busy", 32'(busy), 32'(m_level(cyc) != 0 || m_frame(cyc) >= 0));
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic exp_bits [8];
    logic [7:0] burst [20];
    logic t;
    logic rdy;
    int acc;
    int n;
    int s0;
    int s1;

    exp_bits = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) vecs[i] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
    vecs[3] = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0);
    vecs[4] = mk(1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 1, 1'b1);
    for (int o = 0; o < NVEC - 5; o++) begin
      if (o < BIT) t = 1'b0;
      else if (o < 9 * BIT) t = exp_bits[(o - BIT) / BIT];
      else t = 1'b1;
      vecs[5 + o] = mk(1'b1, 1'b0, 8'h00, t, 1'b1, 0, o < FRAME);
    end

    resetn = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i].resetn, vecs[i].valid, vecs[i].data);
      check_output($sformatf("vec%0d_tx", i), 32'(tx), 32'(vecs[i].tx));
      check_output($sformatf("vec%0d_ready", i), 32'(tx_ready), 32'(vecs[i].ready));
      check_output($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].level));
      check_output($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Stream three bytes; the second push lands on the pop edge of the first.
    fork
      begin
        apply_stimulus(1'b1, 1'b1, 8'h00);
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        check_output("same_edge_level", 32'(level), 32'd1);
        apply_stimulus(1'b1, 1'b1, 8'h55);
        apply_stimulus(1'b1, 1'b0, 8'h00);
      end
      begin
        rx_frame(8'h00, -1, s0);
        rx_frame(8'hFF, s0, s1);
        rx_frame(8'h55, s1, s0);
      end
    join
    wait_idle(200);

    // Twenty-byte burst from idle with valid held high.
    for (int i = 0; i < 20; i++) burst[i] = 8'($urandom);
    acc = 0;
    tx_valid = 1'b1;
    tx_data = burst[0];
    for (int e = 0; e < 17; e++) begin
      rdy = tx_ready;
      @(negedge clk);
      if (rdy) acc++;
      tx_data = burst[acc];
    end
    check_output("burst_accepted17", 32'(acc), 32'd17);
    check_output("burst_full_level", 32'(level), 32'(DEPTH));
    check_output("burst_full_ready", 32'(tx_ready), 32'd0);
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("burst_ready_return", 32'(n), 32'd26);
    rdy = tx_ready;
    @(negedge clk);
    if (rdy) acc++;
    tx_data = burst[acc];
    check_output("burst_ready_pulse", 32'(tx_ready), 32'd0);
    n = 0;
    while (acc < 20 && n < 200) begin
      rdy = tx_ready;
      @(negedge clk);
      if (rdy) acc++;
      if (acc < 20) tx_data = burst[acc];
      n++;
    end
    tx_valid = 1'b0;
    check_output("burst_accepted20", 32'(acc), 32'd20);
    wait_idle(2000);
    check_output("burst_drained_level", 32'(level), 32'd0);

    // Reset in the middle of the data bits with five bytes still queued.
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("midreset_pre_level", 32'(level), 32'd5);
    check_output("midreset_pre_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 1'b0, 8'h00);
    check_output("midreset_tx", 32'(tx), 32'd1);
    check_output("midreset_level", 32'(level), 32'd0);
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_ready", 32'(tx_ready), 32'd0);
    apply_stimulus(1'b1, 1'b0, 8'h00);
    check_output("postreset_ready", 32'(tx_ready), 32'd1);
    check_output("postreset_tx", 32'(tx), 32'd1);

    // Random traffic: alternating heavy and light phases with rare resets.
    for (int i = 0; i < 3000; i++) begin
      apply_stimulus(($urandom_range(0, 999) != 0),
                     ($urandom_range(0, 99) < (((i % 400) < 200) ? 80 : 15)),
                     8'($urandom));
    end
    resetn = 1'b1;
    tx_valid = 1'b0;
    wait_idle(2000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
